// File: rtl/axis_burst_gate_pkg.sv
// axis_burst_gate_pkg: shared FSM encoding and guard counter sizing for the burst gate
package axis_burst_gate_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BURST = 2'd1;
   localparam logic [1:0] ST_GUARD = 2'd2;

   function automatic int guard_width(input int cycles);
      return (cycles < 1) ? 1 : $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/axis_burst_gate_if.sv
// axis_burst_gate_if: AXI-Stream handshake bundle with source (master) and sink (slave) views
interface axis_burst_gate_if #(
   parameter int DATA_WIDTH = 32
);

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_burst_gate_skid_slice.sv
// axis_skid_slice: two-entry registered skid buffer; outputs and s_ready all come from flops
module axis_skid_slice #(
   parameter int DATA_WIDTH = 33
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_valid,
   output logic                  s_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready
);

   logic [DATA_WIDTH-1:0] sk_data;
   logic                  sk_valid;

   assign s_ready = ~sk_valid;

   // output register refills from the skid entry first; a stalled push parks in the skid entry
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_data   <= '0;
         m_valid  <= 1'b0;
         sk_data  <= '0;
         sk_valid <= 1'b0;
      end else if (m_ready || !m_valid) begin
         m_data   <= sk_valid ? sk_data : (s_valid ? s_data : m_data);
         m_valid  <= sk_valid || s_valid;
         sk_valid <= 1'b0;
      end else if (s_valid && !sk_valid) begin
         sk_data  <= s_data;
         sk_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/axis_burst_gate.sv
// axis_burst_gate: releases FIFO data only as whole, tlast-terminated bursts of cfg_data words
module axis_burst_gate
   import axis_burst_gate_pkg::*;
#(
   parameter int AXIS_TDATA_WIDTH = 32,
   parameter int ADDR_WIDTH       = 9,
   parameter int GUARD_CYCLES     = 2
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [ADDR_WIDTH:0]   cfg_data,
   input  logic [ADDR_WIDTH:0]   count,
   axis_burst_gate_if.slave      s_axis,
   axis_burst_gate_if.master     m_axis,
   output logic [31:0]           sts_data,
   output logic                  busy
);

   localparam int GW = guard_width(GUARD_CYCLES);
   localparam logic [ADDR_WIDTH:0] ONE = 1;

   logic [1:0]              state;
   logic [ADDR_WIDTH:0]     remaining;
   logic [GW-1:0]           guard;
   logic                    slice_ready;
   logic                    push;
   logic                    done;
   logic [AXIS_TDATA_WIDTH:0] m_word;

   assign s_axis.tready = (remaining != '0) && slice_ready;
   assign push          = s_axis.tvalid && s_axis.tready;
   assign done          = (state == ST_BURST) && (remaining == '0) &&
                          m_axis.tvalid && m_axis.tready && m_axis.tlast;
   assign {m_axis.tlast, m_axis.tdata} = m_word;

   axis_skid_slice #(
      .DATA_WIDTH(AXIS_TDATA_WIDTH + 1)
   ) u_slice (
      .aclk    (aclk),
      .aresetn (aresetn),
      .s_data  ({remaining == ONE, s_axis.tdata}),
      .s_valid (push),
      .s_ready (slice_ready),
      .m_data  (m_word),
      .m_valid (m_axis.tvalid),
      .m_ready (m_axis.tready)
   );

   // burst sequencing: wait for a full burst in the FIFO, stream it, then idle while count settles
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state     <= ST_IDLE;
         remaining <= '0;
         guard     <= '0;
         sts_data  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cfg_data != '0 && count >= cfg_data) begin
                  state     <= ST_BURST;
                  remaining <= cfg_data;
                  busy      <= 1'b1;
               end
            end
            ST_BURST: begin
               if (push) remaining <= remaining - ONE;
               if (done) begin
                  sts_data <= sts_data + 32'd1;
                  busy     <= 1'b0;
                  guard    <= GW'(GUARD_CYCLES);
                  state    <= (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;
               end
            end
            ST_GUARD: begin
               guard <= guard - GW'(1);
               if (guard <= GW'(1)) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_burst_gate.sv
// tb_axis_burst_gate: directed checks of burst gating, stalls, bubbles, guard spacing and async reset
module tb_axis_burst_gate;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [9:0]  cfg;
   logic [9:0]  count;
   logic [31:0] sts;
   logic        busy;

   axis_burst_gate_if #(.DATA_WIDTH(32)) s_if();
   axis_burst_gate_if #(.DATA_WIDTH(32)) m_if();

   axis_burst_gate #(
      .AXIS_TDATA_WIDTH(32),
      .ADDR_WIDTH(9),
      .GUARD_CYCLES(2)
   ) dut (
      .aclk     (aclk),
      .aresetn  (aresetn),
      .cfg_data (cfg),
      .count    (count),
      .s_axis   (s_if.slave),
      .m_axis   (m_if.master),
      .sts_data (sts),
      .busy     (busy)
   );

   always #5 aclk = ~aclk;

   logic [31:0] q[$];
   logic [31:0] rx_d[$];
   logic        rx_l[$];
   int          rx_t[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc_n = 0;
   int          count_ovr;
   bit          drop, tr_mode, s_fire, m_fire;
   logic [31:0] pend_d;
   logic        pend_l;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      count       = (count_ovr >= 0) ? 10'(count_ovr) : 10'(q.size());
      s_if.tvalid = (q.size() != 0) && !drop;
      s_if.tdata  = (q.size() != 0) ? q[0] : 32'd0;
      m_if.tready = tr_mode ? ~m_if.tready : 1'b1;
      s_fire      = s_if.tvalid && s_if.tready;
      m_fire      = m_if.tvalid && m_if.tready;
      pend_d      = m_if.tdata;
      pend_l      = m_if.tlast;
   endtask

   task automatic cyc();
      @(posedge aclk);
      #1;
      cyc_n++;
      if (s_fire && aresetn) void'(q.pop_front());
      if (m_fire && aresetn) begin
         rx_d.push_back(pend_d);
         rx_l.push_back(pend_l);
         rx_t.push_back(cyc_n);
      end
      drive();
   endtask

   task automatic clear_rx();
      rx_d.delete();
      rx_l.delete();
      rx_t.delete();
   endtask

   task automatic reset_pulse();
      aresetn   = 1'b0;
      drop      = 1'b0;
      tr_mode   = 1'b0;
      count_ovr = -1;
      cfg       = 10'd0;
      q.delete();
      clear_rx();
      drive();
      cyc();
      cyc();
      aresetn = 1'b1;
      drive();
   endtask

   task automatic fill(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) q.push_back(base + 32'(i));
      drive();
   endtask

   task automatic wait_rx(input int n, input int budget);
      for (int i = 0; i < budget && rx_d.size() < n; i++) cyc();
      chk("beat_count", 32'(rx_d.size()), 32'(n));
   endtask

   task automatic check_rx(input logic [31:0] base, input int n, input int len);
      for (int i = 0; i < n && i < rx_d.size(); i++) begin
         chk($sformatf("data[%0d]", i), rx_d[i], base + 32'(i));
         chk($sformatf("last[%0d]", i), 32'(rx_l[i]), 32'(((i + 1) % len) == 0));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_s_tready"}, 32'(s_if.tready), 32'd0);
      chk({tag, "_m_tvalid"}, 32'(m_if.tvalid), 32'd0);
      chk({tag, "_m_tlast"}, 32'(m_if.tlast), 32'd0);
      chk({tag, "_m_tdata"}, m_if.tdata, 32'd0);
      chk({tag, "_sts"}, sts, 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      aresetn     = 1'b1;
      cfg         = 10'd0;
      count_ovr   = -1;
      drop        = 1'b0;
      tr_mode     = 1'b0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      drive();
      #3 aresetn = 1'b0;
      #1 check_zero("reset");

      // burst of 8 held back until count reaches 8
      reset_pulse();
      cfg = 10'd8;
      fill(32'h10, 8);
      for (int c = 0; c < 8; c++) begin
         count_ovr = c;
         drive();
         cyc();
         chk($sformatf("t1_no_ready_c%0d", c), 32'(s_if.tready), 32'd0);
         chk($sformatf("t1_no_valid_c%0d", c), 32'(m_if.tvalid), 32'd0);
      end
      count_ovr = -1;
      drive();
      cyc();
      chk("t1_busy_start", 32'(busy), 32'd1);
      chk("t1_ready_start", 32'(s_if.tready), 32'd1);
      wait_rx(8, 40);
      check_rx(32'h10, 8, 8);
      if (rx_t.size() == 8) chk("t1_gapless_span", 32'(rx_t[7] - rx_t[0]), 32'd7);
      repeat (4) cyc();
      chk("t1_sts", sts, 32'd1);
      chk("t1_busy_end", 32'(busy), 32'd0);

      // three bursts of 4 under a toggling downstream ready
      reset_pulse();
      cfg     = 10'd4;
      tr_mode = 1'b1;
      fill(32'h20, 12);
      wait_rx(12, 200);
      check_rx(32'h20, 12, 4);
      repeat (6) cyc();
      chk("t2_sts", sts, 32'd3);
      chk("t2_busy", 32'(busy), 32'd0);
      chk("t2_ready_idle", 32'(s_if.tready), 32'd0);

      // disabled gate, then an unreachable burst length
      reset_pulse();
      count_ovr = 512;
      fill(32'h30, 4);
      for (int c = 0; c < 6; c++) begin
         cyc();
         chk("t3_off_ready", 32'(s_if.tready), 32'd0);
         chk("t3_off_valid", 32'(m_if.tvalid), 32'd0);
      end
      chk("t3_off_sts", sts, 32'd0);
      cfg = 10'd600;
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("t3_big_ready", 32'(s_if.tready), 32'd0);
         chk("t3_big_busy", 32'(busy), 32'd0);
      end

      // single-word bursts spaced by the guard interval
      reset_pulse();
      cfg = 10'd1;
      fill(32'h40, 3);
      wait_rx(3, 60);
      check_rx(32'h40, 3, 1);
      if (rx_t.size() == 3) begin
         chk("t4_gap0", 32'(rx_t[1] - rx_t[0]), 32'd5);
         chk("t4_gap1", 32'(rx_t[2] - rx_t[1]), 32'd5);
      end

      // source bubbles mid-burst
      reset_pulse();
      cfg = 10'd16;
      fill(32'h50, 16);
      wait_rx(6, 40);
      drop = 1'b1;
      drive();
      repeat (5) cyc();
      chk("t5_drained", 32'(rx_d.size()), 32'd7);
      chk("t5_busy_hold", 32'(busy), 32'd1);
      drop = 1'b0;
      drive();
      wait_rx(16, 60);
      check_rx(32'h50, 16, 16);
      repeat (4) cyc();
      chk("t5_sts", sts, 32'd1);

      // asynchronous reset after three words, then a fresh burst
      reset_pulse();
      cfg = 10'd8;
      fill(32'h60, 8);
      wait_rx(3, 40);
      #2 aresetn = 1'b0;
      #1 check_zero("t6_async");
      q.delete();
      clear_rx();
      fill(32'h70, 8);
      cyc();
      cyc();
      aresetn = 1'b1;
      drive();
      wait_rx(8, 40);
      check_rx(32'h70, 8, 8);
      repeat (4) cyc();
      chk("t6_sts", sts, 32'd1);
      chk("t6_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
